// File: rtl/game_sequencer.sv
// game_sequencer: per-frame game controller for the ball-and-paddle playfield.
// Holds/serves the ball, detects ball loss and board clear, sweeps the brick
// array back to "present", and pulses the stats block (stats_reset, declives).
// Optional pause support is compiled in when GAME_SEQ_PAUSE_EN is defined.
module game_sequencer #(
   parameter int unsigned NUM_BRICKS   = 128,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned LOST_FRAMES  = 90,
   parameter int          LOST_Y       = 240
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               vsync,
   input  logic               start_btn,
   input  logic               pause_btn,
   input  logic               brick_hit,
   input  logic signed [11:0] ball_y,
   input  logic        [3:0]  lives,
   output logic               ball_hold,
   output logic               ball_run,
   output logic               declives,
   output logic               stats_reset,
   output logic               brick_we,
   output logic        [6:0]  brick_addr,
   output logic        [3:0]  level,
   output logic        [2:0]  state,
   output logic               game_over
);

   typedef enum logic [2:0] {
      StAttract  = 3'd0,
      StClear    = 3'd1,
      StServe    = 3'd2,
      StPlay     = 3'd3,
      StLost     = 3'd4,
      StGameOver = 3'd5,
      StPause    = 3'd6
   } state_e;

   localparam logic        [6:0]  ClrLast   = 7'(NUM_BRICKS - 1);
   localparam logic        [8:0]  HitFull   = 9'(NUM_BRICKS);
   localparam logic        [7:0]  ServeLast = 8'(SERVE_FRAMES);
   localparam logic        [7:0]  LostLast  = 8'(LOST_FRAMES);
   localparam logic signed [11:0] LostY     = 12'(LOST_Y);

   state_e      state_q, state_d;
   logic        vsync_q;
   logic [1:0]  start_sync_q;
   logic        start_prev_q, start_edge_q;
   logic [6:0]  clr_cnt_q, clr_cnt_d;
   logic [7:0]  frm_q, frm_d, frm_inc;
   logic [7:0]  hit_q, hit_d;
   logic [8:0]  hit_inc;
   logic [3:0]  level_q, level_d;
   logic        ball_hold_q, ball_hold_d, ball_run_q, ball_run_d;
   logic        declives_q, declives_d, stats_reset_q, stats_reset_d;
   logic        brick_we_q, brick_we_d, game_over_q, game_over_d;
   logic        frame_tick;
   logic        pause_edge;

   assign frame_tick = vsync & ~vsync_q;

`ifdef GAME_SEQ_PAUSE_EN
   logic [1:0] pause_sync_q;
   logic       pause_prev_q, pause_edge_q;

   // Pause button: 2-flop synchronizer followed by a registered rising-edge pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pause_sync_q <= '0;
         pause_prev_q <= 1'b0;
         pause_edge_q <= 1'b0;
      end else begin
         pause_sync_q <= {pause_sync_q[0], pause_btn};
         pause_prev_q <= pause_sync_q[1];
         pause_edge_q <= pause_sync_q[1] & ~pause_prev_q;
      end
   end

   assign pause_edge = pause_edge_q;
`else
   logic unused_pause_btn;
   assign unused_pause_btn = pause_btn;
   assign pause_edge       = 1'b0;
`endif

   // State, counters, synchronizers and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StAttract;
         vsync_q       <= 1'b0;
         start_sync_q  <= '0;
         start_prev_q  <= 1'b0;
         start_edge_q  <= 1'b0;
         clr_cnt_q     <= '0;
         frm_q         <= '0;
         hit_q         <= '0;
         level_q       <= '0;
         ball_hold_q   <= 1'b1;
         ball_run_q    <= 1'b0;
         declives_q    <= 1'b0;
         stats_reset_q <= 1'b0;
         brick_we_q    <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         vsync_q       <= vsync;
         start_sync_q  <= {start_sync_q[0], start_btn};
         start_prev_q  <= start_sync_q[1];
         start_edge_q  <= start_sync_q[1] & ~start_prev_q;
         clr_cnt_q     <= clr_cnt_d;
         frm_q         <= frm_d;
         hit_q         <= hit_d;
         level_q       <= level_d;
         ball_hold_q   <= ball_hold_d;
         ball_run_q    <= ball_run_d;
         declives_q    <= declives_d;
         stats_reset_q <= stats_reset_d;
         brick_we_q    <= brick_we_d;
         game_over_q   <= game_over_d;
      end
   end

   // Next state plus the sweep, frame, hit and level counters.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = '0;
      frm_d     = frm_q;
      hit_d     = hit_q;
      level_d   = level_q;
      frm_inc   = frm_q + 8'd1;
      hit_inc   = {1'b0, hit_q} + 9'd1;
      case (state_q)
         StAttract, StGameOver: begin
            if (start_edge_q) begin
               state_d = StClear;
               level_d = '0;
               hit_d   = '0;
            end
         end
         StClear: begin
            if (clr_cnt_q == ClrLast) state_d = StServe;
            else                      clr_cnt_d = clr_cnt_q + 7'd1;
         end
         StServe: begin
            if (frame_tick) begin
               if (frm_inc == ServeLast) state_d = StPlay;
               else                      frm_d   = frm_inc;
            end
         end
         StPlay: begin
            // Board clear takes priority over a simultaneous loss.
            if (brick_hit && (hit_inc == HitFull)) begin
               hit_d   = '0;
               state_d = StClear;
               if (level_q != 4'hf) level_d = level_q + 4'd1;
            end else begin
               if (brick_hit) hit_d = hit_inc[7:0];
               if (frame_tick && (ball_y >= LostY)) state_d = StLost;
               else if (pause_edge)                 state_d = StPause;
            end
         end
         StLost: begin
            if (frame_tick) begin
               if (frm_inc == LostLast) state_d = (lives == 4'd0) ? StGameOver : StServe;
               else                     frm_d   = frm_inc;
            end
         end
         StPause: begin
            if (pause_edge) state_d = StPlay;
         end
         default: state_d = StAttract;
      endcase
      // Frame counter starts from zero in every newly entered state.
      if (state_d != state_q) frm_d = '0;
   end

   // Output decode from the next state so outputs register alongside the state.
   always_comb begin
      ball_hold_d   = 1'b1;
      ball_run_d    = 1'b0;
      game_over_d   = 1'b0;
      case (state_d)
         StPlay: begin
            ball_hold_d = 1'b0;
            ball_run_d  = 1'b1;
         end
         StPause:    ball_hold_d = 1'b0;
         StGameOver: game_over_d = 1'b1;
         default: ;
      endcase
      brick_we_d    = (state_d == StClear);
      stats_reset_d = (state_d == StClear) &&
                      ((state_q == StAttract) || (state_q == StGameOver));
      declives_d    = (state_q == StPlay) && (state_d == StLost);
   end

   assign ball_hold   = ball_hold_q;
   assign ball_run    = ball_run_q;
   assign declives    = declives_q;
   assign stats_reset = stats_reset_q;
   assign brick_we    = brick_we_q;
   assign brick_addr  = clr_cnt_q;
   assign level       = level_q;
   assign state       = state_q;
   assign game_over   = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: randomized bench for game_sequencer with a scoreboard of
// expected state entries and a negedge monitor that checks sweeps, frame
// counts and pulses. Define GAME_SEQ_PAUSE_EN to exercise the pause feature.
module tb_game_sequencer;

   localparam int NB = 128;
   localparam int SF = 60;
   localparam int LF = 90;
   localparam int LY = 240;
   localparam int FP = 32;  // clk cycles per frame

   localparam logic [2:0] S_ATTRACT  = 3'd0;
   localparam logic [2:0] S_CLEAR    = 3'd1;
   localparam logic [2:0] S_SERVE    = 3'd2;
   localparam logic [2:0] S_PLAY     = 3'd3;
   localparam logic [2:0] S_LOST     = 3'd4;
   localparam logic [2:0] S_GAMEOVER = 3'd5;
   localparam logic [2:0] S_PAUSE    = 3'd6;

   typedef struct packed {
      logic [2:0] st;
      logic [3:0] lvl;
      logic       stats;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               vsync = 1'b0;
   logic               start_btn = 1'b0;
   logic               pause_btn = 1'b0;
   logic               brick_hit = 1'b0;
   logic signed [11:0] ball_y = '0;
   logic        [3:0]  lives = 4'd3;
   logic               ball_hold, ball_run, declives, stats_reset, brick_we, game_over;
   logic        [6:0]  brick_addr;
   logic        [3:0]  level;
   logic        [2:0]  state;

   int   n_vec = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   m_level = 0;
   int   m_hits = 0;
   exp_t exp_q[$];

   game_sequencer #(
      .NUM_BRICKS  (NB),
      .SERVE_FRAMES(SF),
      .LOST_FRAMES (LF),
      .LOST_Y      (LY)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .vsync      (vsync),
      .start_btn  (start_btn),
      .pause_btn  (pause_btn),
      .brick_hit  (brick_hit),
      .ball_y     (ball_y),
      .lives      (lives),
      .ball_hold  (ball_hold),
      .ball_run   (ball_run),
      .declives   (declives),
      .stats_reset(stats_reset),
      .brick_we   (brick_we),
      .brick_addr (brick_addr),
      .level      (level),
      .state      (state),
      .game_over  (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [2:0] st, input int lvl, input logic stats);
      exp_t e;
      e.st    = st;
      e.lvl   = 4'(lvl);
      e.stats = stats;
      exp_q.push_back(e);
   endtask

   // One clock: inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      brick_hit = 1'b0;
      cyc++;
      vsync = ((cyc % FP) < 4);
   endtask

   function automatic logic signed [11:0] low_y();
      int v;
      v = int'($urandom_range(0, 2047 + LY)) - 2048;
      return 12'(v);
   endfunction

   // Bounded wait; hits outside PLAY are injected as noise the DUT must ignore.
   task automatic wait_state(input logic [2:0] s, input int budget);
      int n;
      n = 0;
      while (state !== s && n < budget) begin
         step();
         n++;
         if (state !== S_PLAY && $urandom_range(0, 1) == 1) brick_hit = 1'b1;
      end
      check("wait_state_reached", int'(state), int'(s));
   endtask

   task automatic press_start();
      int k;
      k = int'($urandom_range(4, 8));
      for (int i = 0; i < k; i++) begin
         step();
         start_btn = 1'b1;
      end
      step();
      start_btn = 1'b0;
   endtask

   task automatic do_loss(input int lv);
      int n;
      lives = 4'(lv);
      n = int'($urandom_range(20, 200));
      for (int i = 0; i < n; i++) begin
         step();
         ball_y = low_y();
         if (i == n / 2) start_btn = 1'b1;      // ignored in PLAY
         if (i == n / 2 + 5) start_btn = 1'b0;
         if (m_hits < NB - 2 && $urandom_range(0, 3) == 0) begin
            brick_hit = 1'b1;
            m_hits++;
         end
      end
      step();
      ball_y = 12'($urandom_range(LY, 2047));
      push(S_LOST, m_level, 1'b0);
      wait_state(S_LOST, 2 * FP + 4);
      ball_y = low_y();
      if (lv == 0) begin
         push(S_GAMEOVER, m_level, 1'b0);
         wait_state(S_GAMEOVER, LF * FP + FP + 20);
         for (int i = 0; i < 10; i++) step();
         m_level = 0;
         m_hits  = 0;
         push(S_CLEAR, 0, 1'b1);
         push(S_SERVE, 0, 1'b0);
         push(S_PLAY, 0, 1'b0);
         press_start();
      end else begin
         push(S_SERVE, m_level, 1'b0);
         push(S_PLAY, m_level, 1'b0);
         wait_state(S_SERVE, LF * FP + FP + 20);
      end
      wait_state(S_PLAY, NB + SF * FP + 2 * FP + 50);
   endtask

   task automatic do_clear();
      lives = 4'($urandom_range(1, 3));
      while (m_hits < NB - 1) begin
         step();
         ball_y = low_y();
         if ($urandom_range(0, 1) == 1) begin
            brick_hit = 1'b1;
            m_hits++;
         end
      end
      // Final hit lands on the same cycle as a loss-qualifying frame tick.
      do begin
         step();
         ball_y = low_y();
      end while (cyc % FP != 0);
      brick_hit = 1'b1;
      ball_y    = 12'sd300;
      m_hits    = 0;
      m_level   = (m_level < 15) ? m_level + 1 : 15;
      push(S_CLEAR, m_level, 1'b0);
      push(S_SERVE, m_level, 1'b0);
      push(S_PLAY, m_level, 1'b0);
      step();
      ball_y = low_y();
      wait_state(S_PLAY, NB + SF * FP + 2 * FP + 50);
   endtask

   task automatic do_pause();
      for (int i = 0; i < 4; i++) begin
         step();
         ball_y    = low_y();
         pause_btn = 1'b1;
      end
      step();
      pause_btn = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
      push(S_PAUSE, m_level, 1'b0);
      wait_state(S_PAUSE, 20);
      for (int i = 0; i < 60; i++) begin
         step();
         if ($urandom_range(0, 1) == 1) brick_hit = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         step();
         pause_btn = 1'b1;
      end
      step();
      pause_btn = 1'b0;
      push(S_PLAY, m_level, 1'b0);
      wait_state(S_PLAY, 20);
`else
      for (int i = 0; i < 20; i++) step();
      check("pause_ignored_state", int'(state), int'(S_PLAY));
`endif
   endtask

   // Stimulus: reset, aborted sweep, then a series of game rounds.
   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", state, S_ATTRACT);
      check("rst_ball_hold", ball_hold, 1);
      check("rst_ball_run", ball_run, 0);
      check("rst_declives", declives, 0);
      check("rst_stats_reset", stats_reset, 0);
      check("rst_brick_we", brick_we, 0);
      check("rst_brick_addr", brick_addr, 0);
      check("rst_level", level, 0);
      check("rst_game_over", game_over, 0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step();

      push(S_CLEAR, 0, 1'b1);
      press_start();
      wait_state(S_CLEAR, 20);
      for (int i = 0; i < int'($urandom_range(5, 60)); i++) step();
      push(S_ATTRACT, 0, 1'b0);
      reset = 1'b0;
      #1;
      check("midclr_rst_state", state, S_ATTRACT);
      check("midclr_rst_brick_we", brick_we, 0);
      check("midclr_rst_brick_addr", brick_addr, 0);
      for (int i = 0; i < 3; i++) step();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step();

      push(S_CLEAR, 0, 1'b1);
      push(S_SERVE, 0, 1'b0);
      push(S_PLAY, 0, 1'b0);
      press_start();
      wait_state(S_PLAY, NB + SF * FP + 2 * FP + 50);

      do_pause();
      do_loss(2);
      do_clear();
      do_loss(0);
      for (int r = 0; r < 5; r++) begin
         if ($urandom_range(0, 1) == 1) do_clear();
         else do_loss(int'($urandom_range(0, 3)));
      end
      for (int i = 0; i < 10; i++) step();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, state %0d", state);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // Monitor: state entries are popped from the scoreboard; sweep addresses,
   // frame counts per state and one-cycle pulses are checked every cycle.
   logic [2:0] prev_state = 3'd0;
   logic       tick_pend  = 1'b0;
   logic       vsync_last = 1'b0;
   int         serve_ticks = 0;
   int         lost_ticks = 0;
   int         clr_idx = 0;

   always @(negedge clk) begin
      exp_t e;
      logic dec_exp, stats_exp;
      dec_exp   = 1'b0;
      stats_exp = 1'b0;
      if (tick_pend && prev_state == S_SERVE) serve_ticks++;
      if (tick_pend && prev_state == S_LOST) lost_ticks++;
      if (state != prev_state) begin
         if (reset) begin
            if (prev_state == S_CLEAR) check("sweep_len", clr_idx, NB);
            if (prev_state == S_SERVE) check("serve_frames", serve_ticks, SF);
            if (prev_state == S_LOST) check("lost_frames", lost_ticks, LF);
         end
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_state: got %0d, required no change from %0d",
                     state, prev_state);
         end else begin
            e = exp_q.pop_front();
            check("state", state, e.st);
            check("level", level, e.lvl);
            stats_exp = e.stats && (state == S_CLEAR);
         end
         check("game_over", game_over, (state == S_GAMEOVER));
         if (state == S_PLAY) begin
            check("play_ball_run", ball_run, 1);
            check("play_ball_hold", ball_hold, 0);
         end else if (state == S_PAUSE) begin
            check("pause_ball_run", ball_run, 0);
            check("pause_ball_hold", ball_hold, 0);
         end else if (state != S_LOST) begin
            check("held_ball_run", ball_run, 0);
            check("held_ball_hold", ball_hold, 1);
         end
         dec_exp     = (state == S_LOST) && (prev_state == S_PLAY);
         clr_idx     = 0;
         serve_ticks = 0;
         lost_ticks  = 0;
      end
      check("brick_we", brick_we, (state == S_CLEAR));
      if (state == S_CLEAR) begin
         check("brick_addr", brick_addr, clr_idx);
         clr_idx++;
      end
      if (declives || dec_exp) check("declives", declives, dec_exp);
      if (stats_reset || stats_exp) check("stats_reset", stats_reset, stats_exp);
      prev_state = state;
      tick_pend  = vsync && !vsync_last;
      vsync_last = vsync;
   end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller for the ball-and-paddle playfield. It decides when the ball is held at the serve position and when it moves, and it detects ball loss and board clear. It also sweeps the brick array back to "all present", and drives the lives and score statistics block through `stats_reset` and `declives` pulses. It runs in the pixel-clock domain alongside the sync generator and takes per-frame decisions from `vsync`.

## Interface
Parameters:
- `NUM_BRICKS`, 128: bricks per board; brick array depth.
- `SERVE_FRAMES`, 60: frames held in SERVE before the ball is released (1..255).
- `LOST_FRAMES`, 90: frames spent in LOST after a miss (1..255).
- `LOST_Y`, 240: signed ball_y threshold; at or beyond it the ball is lost.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `vsync`  in  1  vertical sync, synchronous to `clk`, active-high.
- `start_btn`  in  1  raw start button, active-high, asynchronous.
- `pause_btn`  in  1  raw pause button, active-high, asynchronous. Used only with `GAME_SEQ_PAUSE_EN`.
- `brick_hit`  in  1  one-cycle pulse per brick destroyed (the score increment strobe).
- `ball_y`  in  12  signed ball Y position.
- `lives`  in  4  lives remaining, from the stats block.
- `ball_hold`  out  1  forces the ball to its serve position.
- `ball_run`  out  1  enables per-frame ball motion.
- `declives`  out  1  one-cycle pulse that decrements lives.
- `stats_reset`  out  1  one-cycle pulse that resets score and lives.
- `brick_we`  out  1  brick array write enable (write data is always 0, meaning present).
- `brick_addr`  out  7  brick array write address.
- `level`  out  4  board-clear count, saturating at 15.
- `state`  out  3  current state encoding.
- `game_over`  out  1  high in GAMEOVER.

## Operation
- **Frame tick.** `frame_tick` is `vsync & ~vsync_d`, where `vsync_d` is `vsync` registered. It is one cycle long, per frame.
- **Button inputs.** Each button passes through a 2-flop synchronizer, then a rising-edge detector. One press produces one edge pulse.
- **State encoding.** ATTRACT=0, CLEAR=1, SERVE=2, PLAY=3, LOST=4, GAMEOVER=5, PAUSE=6.
- **ATTRACT**
  - Outputs: `ball_hold`=1, `ball_run`=0.
  - A start edge pulses `stats_reset`, clears `level` and the hit count, and goes to CLEAR.
- **CLEAR**
  - `brick_we`=1 for exactly `NUM_BRICKS` consecutive cycles, with `brick_addr` stepping 0..`NUM_BRICKS`-1.
  - Then go to SERVE; the serve counter is zeroed.
- **SERVE**
  - Count frame ticks. At the `SERVE_FRAMES`-th tick, go to PLAY.
- **PLAY**
  - Outputs: `ball_run`=1, `ball_hold`=0.
  - Each `brick_hit` increments the 8-bit hit count.
  - When the count reaches `NUM_BRICKS`: zero the count, increment `level` (saturating at 15), and go to CLEAR.
  - Otherwise, on a frame tick with signed `ball_y >= LOST_Y`: pulse `declives` and go to LOST.
- **LOST**
  - Count `LOST_FRAMES` frame ticks. On the last tick:
    - `lives==0`: go to GAMEOVER.
    - otherwise: go to SERVE.
  - `lives` is sampled only at this tick, so the decrement has long since settled.
- **GAMEOVER**
  - `game_over`=1, `ball_hold`=1.
  - A start edge behaves as it does in ATTRACT.
- **Brick hits outside PLAY** are ignored.
- **Start edges** in CLEAR, SERVE, PLAY, LOST or PAUSE are ignored.

## Timing
- **Reset values.**
  - State ATTRACT, so `state`=0.
  - `ball_hold`=1, `ball_run`=0, `declives`=0, `stats_reset`=0, `brick_we`=0, `brick_addr`=0, `level`=0, `game_over`=0.
  - All counters and synchronizers are 0.
- **Registered outputs.** All outputs are registered and decoded from the current state. A transition decided at cycle N is visible at N+1.
- **Start latency.** A start press reaches the edge pulse after 3 clk cycles. `stats_reset` is high on the cycle the state enters CLEAR.
- **Brick clear.** `brick_we` is high on the first CLEAR cycle, with `brick_addr`=0. SERVE is entered on the cycle after `brick_addr`=`NUM_BRICKS`-1.
- **Simultaneous board clear and loss.** If the final `brick_hit` arrives in the same cycle as a loss-qualifying frame tick, board clear wins. No `declives` pulse is issued.
- **Hit during the last CLEAR cycle** is not counted.
- **Loss check** happens only on frame ticks, so at most one `declives` pulse per miss.
- **Asynchronous reset mid-CLEAR** abandons the sweep. The next start re-sweeps the whole array from address 0.
- **Counters.** The serve and LOST frame counters are 8-bit and are zeroed on entry to their state.

## Configuration
- **`GAME_SEQ_PAUSE_EN` defined:**
  - A pause edge in PLAY goes to PAUSE, with `ball_hold`=0 and `ball_run`=0; the ball freezes in place.
  - A pause edge in PAUSE returns to PLAY.
  - The hit count and `level` are preserved across the pause.
  - `brick_hit` is ignored in PAUSE.
- **Not defined:**
  - `pause_btn` is ignored and state 6 is unreachable.
  - The synchronizer and edge logic for `pause_btn` are not generated.

## Test plan
- **Reset then start.** Release reset, pulse start 4 cycles → `stats_reset` is one cycle high; 128 cycles of `brick_we` with addresses 0..127; then `state`=2.
- **Serve timing.** With `SERVE_FRAMES`=60 → `state`=3 one cycle after the 60th frame tick; `ball_run`=1.
- **Ball loss.** Set `ball_y`=240 in PLAY with `lives`=2 → one `declives` pulse at the frame tick; 90 frames later `state`=2. Repeat with `lives`=0 → `state`=5 and `game_over`=1.
- **Board clear.** Issue 128 `brick_hit` pulses in PLAY → `level`=1, a CLEAR sweep of 128 writes, then SERVE. The 128th hit coincides with a `ball_y`=300 frame tick → no `declives`.
- **Pause** (with `GAME_SEQ_PAUSE_EN`). Pause edge in PLAY → `state`=6 and `ball_run`=0; hits are ignored; a second edge → `state`=3 with the hit count unchanged.
